// File: rtl/toggle_port_responder.sv
// Toggle-handshake memory responder: serves one read or write at a time from an
// internal word RAM after a programmable, stallable latency, acking by toggle.
module toggle_port_responder #(
  parameter int unsigned addrwidth = 8,
  parameter int unsigned datawidth = 16,
  parameter int unsigned rdlatency = 3,
  parameter int unsigned wrlatency = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [addrwidth:1]   a,
  input  logic [datawidth-1:0] d,
  input  logic                 we,
  output logic [datawidth-1:0] q,
  input  logic                 rd_req,
  output logic                 rd_ack,
  input  logic                 wr_req,
  output logic                 wr_ack,
  input  logic                 stall,
  output logic                 busy,
  output logic                 protocol_err,
  output logic [31:0]          rdcount,
  output logic [31:0]          wrcount
);

  localparam int unsigned depth = 2 ** addrwidth;
  localparam int unsigned cntw  = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state;
  logic                 rd_req_q;
  logic                 wr_req_q;
  logic [cntw-1:0]      cnt;
  logic                 chan_wr;
  logic [addrwidth-1:0] a_cap;
  logic [datawidth-1:0] d_cap;
  logic [datawidth-1:0] mem [depth];

  logic rd_pend_c;
  logic wr_pend_c;
  logic done_c;
  logic withdrawn_c;
  logic mem_we_c;

  // Pending is judged on the registered request so capture lands one edge after the toggle.
  assign rd_pend_c   = rd_req_q != rd_ack;
  assign wr_pend_c   = wr_req_q != wr_ack;
  assign done_c      = (state == BUSY) && !stall && (cnt == '0);
  assign withdrawn_c = (state == BUSY) && (chan_wr ? !wr_pend_c : !rd_pend_c);
  assign mem_we_c    = reset_n && done_c && chan_wr;

  // RAM has no reset; a write discarded by reset never reaches it.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[a_cap] <= d_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_ack       <= 1'b0;
      wr_ack       <= 1'b0;
      q            <= '0;
      protocol_err <= 1'b0;
      rdcount      <= '0;
      wrcount      <= '0;
      cnt          <= '0;
      chan_wr      <= 1'b0;
      a_cap        <= '0;
      d_cap        <= '0;
    end else begin
      rd_req_q <= rd_req;
      wr_req_q <= wr_req;
      case (state)
        IDLE: begin
          if (wr_pend_c) begin
            a_cap   <= a;
            d_cap   <= d;
            chan_wr <= 1'b1;
            cnt     <= cntw'(wrlatency - 1);
            state   <= BUSY;
            busy    <= 1'b1;
            if (!we) protocol_err <= 1'b1;
          end else if (rd_pend_c) begin
            a_cap   <= a;
            d_cap   <= d;
            chan_wr <= 1'b0;
            cnt     <= cntw'(rdlatency - 1);
            state   <= BUSY;
            busy    <= 1'b1;
            if (we) protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          if (withdrawn_c) protocol_err <= 1'b1;
          if (!stall) begin
            if (cnt != '0) begin
              cnt <= cnt - cntw'(1);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (chan_wr) begin
                wr_ack  <= ~wr_ack;
                wrcount <= wrcount + 32'd1;
              end else begin
                q       <= mem[a_cap];
                rd_ack  <= ~rd_ack;
                rdcount <= rdcount + 32'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
